// File: rtl/led_bar_meter.sv
// LED bar-graph meter with stepped ramp, peak-hold marker and mute blink.
// Drives N_LED outputs from a level input; bit 0 is the bottom LED.
module led_bar_meter #(
  parameter int N_LED       = 8,
  parameter int LVL_W       = 5,
  parameter int INVERT      = 1,
  parameter int STEP_DIV    = 4,
  parameter int HOLD_STEPS  = 2,
  parameter int BLINK_STEPS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] level,
  input  logic             mute,
  input  logic             peak_clr,
  output logic [N_LED-1:0] o_led,
  output logic             o_busy
);

  localparam int CW = $clog2(N_LED + 1);
  localparam int AW = ((LVL_W > CW) ? LVL_W : CW) + 1;
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_STEPS + 2);
  localparam int BW = $clog2(BLINK_STEPS + 1);

  logic [PW-1:0]    r_pre;
  logic [CW-1:0]    r_tgt;
  logic [CW-1:0]    r_cur;
  logic [CW-1:0]    r_peak;
  logic [HW-1:0]    r_hold;
  logic [BW-1:0]    r_bcnt;
  logic             r_phase;
  logic             r_mute_q;
  logic [N_LED-1:0] r_led;
  logic             r_busy;

  logic             w_tick;
  logic [AW-1:0]    w_lvl;
  logic [AW-1:0]    w_nled;
  logic [CW-1:0]    w_tgt;
  logic [CW-1:0]    w_cur_nxt;
  logic [CW-1:0]    w_peak_nxt;
  logic [HW-1:0]    w_hold_nxt;
  logic [BW-1:0]    w_bcnt_nxt;
  logic             w_phase_nxt;
  logic [N_LED-1:0] w_bar;
  logic [N_LED-1:0] w_mark;

  assign w_tick = (r_pre == PW'(STEP_DIV - 1));
  assign w_lvl  = AW'(level);
  assign w_nled = AW'(N_LED);

  always_comb begin
    w_tgt = '0;
    if (w_lvl >= w_nled) begin
      if (INVERT == 0) w_tgt = CW'(N_LED);
    end else if (INVERT != 0) begin
      w_tgt = CW'(w_nled - w_lvl);
    end else begin
      w_tgt = CW'(w_lvl);
    end
  end

  always_comb begin
    w_cur_nxt = r_cur;
    if (w_tick) begin
      if (r_cur < r_tgt)      w_cur_nxt = r_cur + CW'(1);
      else if (r_cur > r_tgt) w_cur_nxt = r_cur - CW'(1);
    end
  end

  always_comb begin
    w_peak_nxt = r_peak;
    w_hold_nxt = r_hold;
    if (peak_clr) begin
      w_peak_nxt = w_cur_nxt;
      w_hold_nxt = '0;
    end else if (w_cur_nxt >= r_peak) begin
      w_peak_nxt = w_cur_nxt;
      w_hold_nxt = HW'(HOLD_STEPS);
    end else if (w_tick) begin
      // cur_next < peak here, so peak-1 never undershoots the bar
      if (r_hold != '0) w_hold_nxt = r_hold - HW'(1);
      else              w_peak_nxt = r_peak - CW'(1);
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_bcnt_nxt  = r_bcnt;
    if (!mute || !r_mute_q) begin
      w_phase_nxt = 1'b0;
      w_bcnt_nxt  = '0;
    end else if (w_tick) begin
      if (r_bcnt == BW'(BLINK_STEPS - 1)) begin
        w_bcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_bcnt_nxt  = r_bcnt + BW'(1);
      end
    end
  end

  always_comb begin
    w_bar  = '0;
    w_mark = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_bar[i]  = (CW'(i) < r_cur);
      w_mark[i] = (r_peak == CW'(i + 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_tgt    <= '0;
      r_cur    <= '0;
      r_peak   <= '0;
      r_hold   <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
      r_mute_q <= 1'b0;
      r_led    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + PW'(1);
      r_tgt    <= w_tgt;
      r_cur    <= w_cur_nxt;
      r_peak   <= w_peak_nxt;
      r_hold   <= w_hold_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_phase  <= w_phase_nxt;
      r_mute_q <= mute;
      r_led    <= (mute & r_phase) ? '0 : (w_bar | w_mark);
      r_busy   <= (r_cur != r_tgt);
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule
